// File: rtl/gfifo_rd_client_if.sv
// gfifo_rd_client_if: gray-FIFO read port (request/data/valid) plus downstream word handshake.
interface gfifo_rd_client_if;
  logic        rd_req_;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic [15:0] out_data;
  logic [2:0]  out_nib;
  logic        out_valid;
  logic        out_ready;
  modport master (output rd_req_, out_data, out_nib, out_valid, input rd_data, rd_valid, out_ready);
  modport slave (input rd_req_, out_data, out_nib, out_valid, output rd_data, rd_valid, out_ready);
endinterface

// File: rtl/gfifo_rd_client.sv
// gfifo_rd_client: packs 4-bit gray-FIFO read beats into 16-bit words for a valid/ready sink.
// Define GFIFO_RD_TMO_EN to enable the idle-timeout partial flush.
module gfifo_rd_client #(
  parameter int RD_LAT = 2,
  parameter int TMO_CYCLES = 15
) (
  input  logic              rd_clk,
  input  logic              rst_,
  gfifo_rd_client_if.master bus,
  input  logic              enable,
  input  logic              flush,
  output logic              busy,
  output logic              err_spur,
  output logic              tmo_flag
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT_OUT, DRAIN} state_t;
  state_t state, state_n;
  logic [RD_LAT-1:0] hist;
  logic [5:0] out_cnt;
  logic [2:0] nib_cnt;
  logic [3:0][3:0] asm_q;
  logic req, cap, free, ld_byp, ld_full, ld_part, ld, flush_any, drain_done;
  always_comb begin
    out_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) out_cnt = out_cnt + 6'(hist[i]);
  end
  assign req = enable && state == FILL && (6'(nib_cnt) + out_cnt < 6'd4);
  assign bus.rd_req_ = !req;
  assign cap = bus.rd_valid && out_cnt != '0 && nib_cnt != 3'd4;
  assign free = !bus.out_valid || bus.out_ready;
  // the fourth nibble goes straight into a free output register, skipping WAIT_OUT
  assign ld_byp = cap && nib_cnt == 3'd3 && free;
  assign ld_full = state == WAIT_OUT && free;
  assign ld_part = state == DRAIN && out_cnt == '0 && nib_cnt != '0 && free;
  assign drain_done = state == DRAIN && out_cnt == '0 && (nib_cnt == '0 || free);
  assign ld = ld_byp || ld_full || ld_part;
  assign busy = !(state == IDLE && out_cnt == '0 && nib_cnt == '0 && !bus.out_valid);
`ifdef GFIFO_RD_TMO_EN
  logic [15:0] tmo_cnt;
  logic tmo_arm, tmo_fire;
  assign tmo_arm = state == FILL && nib_cnt != '0 && nib_cnt != 3'd4 && !bus.rd_valid;
  assign tmo_fire = tmo_arm && tmo_cnt == 16'(TMO_CYCLES - 1);
  assign flush_any = flush || tmo_fire;
  always_ff @(posedge rd_clk or negedge rst_)
    if (!rst_) begin
      tmo_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_cnt <= (tmo_arm && !tmo_fire) ? tmo_cnt + 16'd1 : '0;
      tmo_flag <= tmo_fire;
    end
`else
  assign flush_any = flush;
  assign tmo_flag = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = flush_any ? DRAIN : enable ? FILL : IDLE;
      FILL: state_n = flush_any ? DRAIN :
                      (cap && nib_cnt == 3'd3 && !free) ? WAIT_OUT :
                      (!enable && out_cnt == '0) ? IDLE : FILL;
      WAIT_OUT: state_n = flush_any ? DRAIN : free ? FILL : WAIT_OUT;
      DRAIN: state_n = drain_done ? (enable ? FILL : IDLE) : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge rd_clk or negedge rst_)
    if (!rst_) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge rd_clk or negedge rst_)
    if (!rst_) begin
      hist <= '0;
      nib_cnt <= '0;
      asm_q <= '0;
      err_spur <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_nib <= '0;
    end else begin
      hist <= RD_LAT'({hist, req});
      if (bus.rd_valid && out_cnt == '0) err_spur <= 1'b1;
      if (ld) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= ld_byp ? {bus.rd_data, asm_q[2], asm_q[1], asm_q[0]} : asm_q;
        bus.out_nib <= ld_byp ? 3'd4 : nib_cnt;
        nib_cnt <= '0;
        asm_q <= '0;
      end else begin
        if (bus.out_ready) bus.out_valid <= 1'b0;
        if (cap) begin
          asm_q[nib_cnt[1:0]] <= bus.rd_data;
          nib_cnt <= nib_cnt + 3'd1;
        end
      end
    end
endmodule

// File: tb/tb_gfifo_rd_client.sv
// tb_gfifo_rd_client: FIFO read-port model with fixed latency, word scoreboard, scenario tasks.
module tb_gfifo_rd_client;
  localparam int LAT = 2, TMO = 15;
  logic clk = 0, rst_ = 0, enable = 0, flush = 0, inj = 0;
  logic [3:0] inj_d = 0;
  logic busy, err_spur, tmo_flag;
  int errors = 0, checks = 0, pops = 0, cyc = 0, last_beat_cyc = 0, vrise_cyc = -1, tmo_pulses = 0;
  logic [3:0] fifo_q[$];
  logic [18:0] exp_q[$], got_q[$];
  gfifo_rd_client_if bus();
  gfifo_rd_client #(.RD_LAT(LAT), .TMO_CYCLES(TMO)) dut (
    .rd_clk(clk), .rst_(rst_), .bus(bus), .enable(enable), .flush(flush),
    .busy(busy), .err_spur(err_spur), .tmo_flag(tmo_flag)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  // FIFO read port: a request seen in cycle c returns its nibble in cycle c+LAT
  initial begin
    logic lv[LAT];
    logic [3:0] ld[LAT];
    logic dv;
    logic [3:0] dd;
    for (int i = 0; i < LAT; i++) begin lv[i] = 0; ld[i] = 0; end
    bus.rd_valid = 0;
    bus.rd_data = 0;
    forever begin
      @(negedge clk);
      #2;
      dv = lv[LAT-1];
      dd = ld[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin lv[i] = lv[i-1]; ld[i] = ld[i-1]; end
      lv[0] = 0;
      if (bus.rd_req_ === 1'b0 && fifo_q.size() > 0) begin lv[0] = 1; ld[0] = fifo_q.pop_front(); pops++; end
      bus.rd_valid = dv | inj;
      bus.rd_data = inj ? inj_d : dd;
      if (dv) last_beat_cyc = cyc;
    end
  end
  initial begin
    logic vprev;
    vprev = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_ && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_nib, bus.out_data});
      if (rst_ && bus.out_valid && !vprev) vrise_cyc = cyc;
      vprev = bus.out_valid;
      if (tmo_flag) tmo_pulses++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_flush();
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.rd_req_ !== 1'b1) begin errors++; $display("FAIL reset rd_req_ got=%b exp=1", bus.rd_req_); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset out_data got=%h exp=0000", bus.out_data); end
    checks++; if (bus.out_nib !== 3'd0) begin errors++; $display("FAIL reset out_nib got=%0d exp=0", bus.out_nib); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (err_spur !== 1'b0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL reset flags got=%b%b exp=00", err_spur, tmo_flag); end
    rst_ = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [18:0] g, e;
    pops = 0;
    fifo_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_q.push_back({3'd4, 16'h4321});
    enable = 1;
    bus.out_ready = 1;
    for (int i = 0; i < 40 && got_q.size() < 1; i++) @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic words got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL basic word got=%h exp=%h", g, e); end
    end
    checks++; if (vrise_cyc != last_beat_cyc + 1) begin errors++; $display("FAIL basic latency got=%0d exp=%0d", vrise_cyc, last_beat_cyc + 1); end
    repeat (4) @(negedge clk);
    checks++; if (pops != 4) begin errors++; $display("FAIL basic honored got=%0d exp=4", pops); end
    enable = 0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic idle busy got=%b exp=0", busy); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_empty();
    enable = 1;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rd_req_ !== 1'b0) begin errors++; $display("FAIL empty rd_req_ cycle %0d got=%b exp=0", i, bus.rd_req_); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL empty err_spur got=%b exp=0", err_spur); end
    enable = 0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty busy got=%b exp=0 (nib_cnt must stay 0)", busy); end
  endtask

  task automatic test_backpressure();
    logic [18:0] g, e;
    pops = 0;
    fifo_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    exp_q.push_back({3'd4, 16'h4321});
    exp_q.push_back({3'd4, 16'h8765});
    bus.out_ready = 0;
    enable = 1;
    repeat (25) @(negedge clk);
    checks++; if (pops != 8) begin errors++; $display("FAIL bp honored got=%0d exp=8", pops); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp early words got=%0d exp=0", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4321 || bus.out_nib !== 3'd4 || bus.rd_req_ !== 1'b1) begin
        errors++;
        $display("FAIL bp hold valid=%b data=%h nib=%0d rd_req_=%b exp 1/4321/4/1", bus.out_valid, bus.out_data, bus.out_nib, bus.rd_req_);
      end
      @(negedge clk);
    end
    bus.out_ready = 1;
    for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge clk);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp words got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp word got=%h exp=%h", g, e); end
    end
    enable = 0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp idle busy got=%b exp=0", busy); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    logic [18:0] g, e;
    fifo_q = '{4'h5};
    tmo_pulses = 0;
    bus.out_ready = 1;
    enable = 1;
    exp_q.push_back({3'd1, 16'h0005});
`ifdef GFIFO_RD_TMO_EN
    for (int i = 0; i < 40 && got_q.size() < 1; i++) @(negedge clk);
    checks++; if (tmo_pulses != 1) begin errors++; $display("FAIL tmo pulses got=%0d exp=1", tmo_pulses); end
`else
    repeat (40) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL tmo word without timeout got=%0d exp=0", got_q.size()); end
    checks++; if (tmo_pulses != 0 || busy !== 1'b1) begin errors++; $display("FAIL tmo idle pulses=%0d busy=%b exp 0/1", tmo_pulses, busy); end
    enable = 0;
    repeat (4) @(negedge clk);
    pulse_flush();
    for (int i = 0; i < 20 && got_q.size() < 1; i++) @(negedge clk);
`endif
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL tmo words got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL tmo word got=%h exp=%h", g, e); end
    end
    enable = 0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    logic [18:0] g, e;
    fifo_q = '{4'hA, 4'hB};
    bus.out_ready = 1;
    enable = 1;
    repeat (8) @(negedge clk);
    enable = 0;
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL flush pre words=%0d busy=%b exp 0/1", got_q.size(), busy); end
    exp_q.push_back({3'd2, 16'h00BA});
    pulse_flush();
    for (int i = 0; i < 20 && got_q.size() < 1; i++) @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL flush words got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL flush word got=%h exp=%h", g, e); end
    end
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    pulse_flush();
    repeat (6) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush empty words got=%0d exp=0", got_q.size()); end
    checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL flush pre-spur err_spur got=%b exp=0", err_spur); end
    inj = 1; inj_d = 4'hF;
    @(negedge clk);
    inj = 0;
    @(negedge clk);
    checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur err_spur got=%b exp=1", err_spur); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur discard busy got=%b exp=0", busy); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midword();
    fifo_q = '{4'h1, 4'h2, 4'h3};
    bus.out_ready = 1;
    enable = 1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midword pre busy=%b out_valid=%b exp 1/0", busy, bus.out_valid); end
    #1 rst_ = 0;
    #1;
    checks++;
    if (bus.rd_req_ !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_nib !== 3'd0 ||
        busy !== 1'b0 || err_spur !== 1'b0 || tmo_flag !== 1'b0) begin
      errors++;
      $display("FAIL midword async reset rd_req_=%b valid=%b data=%h nib=%0d busy=%b spur=%b tmo=%b exp 1/0/0000/0/0/0/0",
               bus.rd_req_, bus.out_valid, bus.out_data, bus.out_nib, busy, err_spur, tmo_flag);
    end
    @(negedge clk);
    enable = 0;
    @(negedge clk);
    rst_ = 1;
    repeat (10) @(negedge clk);
    checks++; if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midword after release words=%0d out_valid=%b exp 0/0", got_q.size(), bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midword busy got=%b exp=0", busy); end
    inj = 1; inj_d = 4'h7;
    @(negedge clk);
    inj = 0;
    @(negedge clk);
    checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL midword late beat err_spur got=%b exp=1", err_spur); end
    got_q.delete();
  endtask

  initial begin
    bus.out_ready = 0;
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_timeout();
    test_flush();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
